// File: rtl/cu_rf.sv
// Compute-unit register file: one crossbar write port, two registered
// read ports with write-first bypass and stall hold.
module cu_rf #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk_dcd,
  input  logic                     rst_n,
  input  logic                     ps_xb_stall,
  input  logic [ADDRESS_WIDTH-1:0] ps_xb_wadd,
  input  logic [ADDRESS_WIDTH-1:0] ps_xb_raddx,
  input  logic [ADDRESS_WIDTH-1:0] ps_xb_raddy,
  input  logic                     xb_rf_w_En,
  input  logic [DATA_WIDTH-1:0]    xb_rf_dt,
  output logic [DATA_WIDTH-1:0]    rf_xb_dtx,
  output logic [DATA_WIDTH-1:0]    rf_xb_dty,
  output logic [7:0]               rf_xb_wr_cnt
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DATA_WIDTH-1:0] rd_x;
  logic [DATA_WIDTH-1:0] rd_y;
  logic                  hit_x;
  logic                  hit_y;

  assign hit_x = xb_rf_w_En && (ps_xb_raddx == ps_xb_wadd);
  assign hit_y = xb_rf_w_En && (ps_xb_raddy == ps_xb_wadd);

  always_comb begin
    rd_x = regs[ps_xb_raddx];
    rd_y = regs[ps_xb_raddy];
    if (hit_x) rd_x = xb_rf_dt;
    if (hit_y) rd_y = xb_rf_dt;
  end

  always_ff @(posedge clk_dcd or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (xb_rf_w_En) begin
      regs[ps_xb_wadd] <= xb_rf_dt;
    end
  end

  // Writes and the counter ignore stall; only the read registers freeze.
  always_ff @(posedge clk_dcd or negedge rst_n) begin
    if (!rst_n) begin
      rf_xb_wr_cnt <= '0;
    end else if (xb_rf_w_En) begin
      rf_xb_wr_cnt <= rf_xb_wr_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_dcd or negedge rst_n) begin
    if (!rst_n) begin
      rf_xb_dtx <= '0;
      rf_xb_dty <= '0;
    end else if (!ps_xb_stall) begin
      rf_xb_dtx <= rd_x;
      rf_xb_dty <= rd_y;
    end
  end

endmodule

// File: tb/tb_cu_rf.sv
// Bench for cu_rf: directed scenarios plus random traffic against an
// array-based reference model.
module tb_cu_rf;

  logic        clk_dcd = 1'b0;
  logic        rst_n;
  logic        ps_xb_stall;
  logic [3:0]  ps_xb_wadd;
  logic [3:0]  ps_xb_raddx;
  logic [3:0]  ps_xb_raddy;
  logic        xb_rf_w_En;
  logic [15:0] xb_rf_dt;
  logic [15:0] rf_xb_dtx;
  logic [15:0] rf_xb_dty;
  logic [7:0]  rf_xb_wr_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] m_reg [16];
  logic [15:0] m_x;
  logic [15:0] m_y;
  int          m_cnt;

  cu_rf dut (
    .clk_dcd      (clk_dcd),
    .rst_n        (rst_n),
    .ps_xb_stall  (ps_xb_stall),
    .ps_xb_wadd   (ps_xb_wadd),
    .ps_xb_raddx  (ps_xb_raddx),
    .ps_xb_raddy  (ps_xb_raddy),
    .xb_rf_w_En   (xb_rf_w_En),
    .xb_rf_dt     (xb_rf_dt),
    .rf_xb_dtx    (rf_xb_dtx),
    .rf_xb_dty    (rf_xb_dty),
    .rf_xb_wr_cnt (rf_xb_wr_cnt)
  );

  always #5 clk_dcd = ~clk_dcd;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".dtx"}, rf_xb_dtx, m_x);
    chk({tag, ".dty"}, rf_xb_dty, m_y);
    chk({tag, ".cnt"}, {8'h00, rf_xb_wr_cnt}, 16'(m_cnt % 256));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
    m_x   = 16'h0;
    m_y   = 16'h0;
    m_cnt = 0;
  endtask

  task automatic drive(input logic st, input logic we, input logic [3:0] wa,
                       input logic [15:0] wd, input logic [3:0] rx,
                       input logic [3:0] ry);
    ps_xb_stall = st;
    xb_rf_w_En  = we;
    ps_xb_wadd  = wa;
    xb_rf_dt    = wd;
    ps_xb_raddx = rx;
    ps_xb_raddy = ry;
  endtask

  // Apply one rising edge to the model using the current inputs, then check.
  task automatic tick(input string tag);
    if (!ps_xb_stall) begin
      m_x = (xb_rf_w_En && ps_xb_raddx == ps_xb_wadd) ? xb_rf_dt
                                                       : m_reg[ps_xb_raddx];
      m_y = (xb_rf_w_En && ps_xb_raddy == ps_xb_wadd) ? xb_rf_dt
                                                       : m_reg[ps_xb_raddy];
    end
    if (xb_rf_w_En) begin
      m_reg[ps_xb_wadd] = xb_rf_dt;
      m_cnt++;
    end
    @(posedge clk_dcd);
    #1;
    chk_all(tag);
  endtask

  task automatic pulse_reset();
    drive(1'($urandom), 1'b1, 4'($urandom), 16'($urandom),
          4'($urandom), 4'($urandom));
    @(negedge clk_dcd);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_async.dtx", rf_xb_dtx, 16'h0);
    chk("rst_async.dty", rf_xb_dty, 16'h0);
    chk("rst_async.cnt", {8'h00, rf_xb_wr_cnt}, 16'h0);
    @(posedge clk_dcd);
    #1;
    chk_all("rst_edge");
    @(negedge clk_dcd);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 16'h0, 4'h0, 4'h0);
    model_clear();
    #3;
    pulse_reset();

    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 1'b0, 4'h0, 16'h0, 4'(a), 4'(15 - a));
      tick("rst_read");
      chk("rst_read_zero", rf_xb_dtx, 16'h0);
    end

    drive(1'b0, 1'b1, 4'd3, 16'hA5A5, 4'd0, 4'd0);
    tick("wr_r3");
    drive(1'b0, 1'b0, 4'd0, 16'h0, 4'd3, 4'd4);
    tick("rd_r3");
    chk("rd_r3_val", rf_xb_dtx, 16'hA5A5);
    chk("rd_r4_zero", rf_xb_dty, 16'h0);

    drive(1'b0, 1'b1, 4'd5, 16'h1111, 4'd0, 4'd0);
    tick("wr_r5");
    drive(1'b0, 1'b1, 4'd5, 16'h2222, 4'd5, 4'd5);
    tick("bypass");
    chk("bypass_x", rf_xb_dtx, 16'h2222);
    chk("bypass_y", rf_xb_dty, 16'h2222);

    drive(1'b0, 1'b1, 4'd6, 16'h0001, 4'd0, 4'd0);
    tick("wr_r6");
    drive(1'b0, 1'b0, 4'd0, 16'h0, 4'd6, 4'd6);
    tick("rd_r6");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 4'd6, 16'hBEEF, 4'd6, 4'd6);
      tick("stall");
      chk("stall_hold", rf_xb_dtx, 16'h0001);
    end
    drive(1'b0, 1'b0, 4'd0, 16'h0, 4'd6, 4'd6);
    tick("unstall");
    chk("unstall_val", rf_xb_dtx, 16'hBEEF);

    drive(1'b0, 1'b1, 4'd1, 16'h00AA, 4'd0, 4'd0);
    tick("wr_r1");
    drive(1'b0, 1'b1, 4'd2, 16'h00BB, 4'd0, 4'd0);
    tick("wr_r2");
    drive(1'b0, 1'b0, 4'd0, 16'h0, 4'd1, 4'd2);
    tick("dual");
    chk("dual_x", rf_xb_dtx, 16'h00AA);
    chk("dual_y", rf_xb_dty, 16'h00BB);
    drive(1'b0, 1'b0, 4'd0, 16'h0, 4'd2, 4'd1);
    tick("swap");
    chk("swap_x", rf_xb_dtx, 16'h00BB);
    chk("swap_y", rf_xb_dty, 16'h00AA);

    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1'($urandom), 1'b1, 4'($urandom), 16'($urandom),
            4'($urandom), 4'($urandom));
      tick("wrap_wr");
    end
    chk("wrap_cnt", {8'h00, rf_xb_wr_cnt}, 16'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 1'b0, 4'($urandom), 16'($urandom),
            4'($urandom), 4'($urandom));
      tick("idle");
    end
    chk("idle_cnt", {8'h00, rf_xb_wr_cnt}, 16'h0);
    drive(1'b0, 1'b1, 4'd9, 16'h1234, 4'd9, 4'd0);
    tick("one_wr");
    chk("one_wr_cnt", {8'h00, rf_xb_wr_cnt}, 16'h1);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] wa;
      wa = 4'($urandom);
      drive(($urandom_range(3, 0) == 0), 1'($urandom), wa, 16'($urandom),
            ($urandom_range(2, 0) == 0) ? wa : 4'($urandom),
            ($urandom_range(2, 0) == 0) ? wa : 4'($urandom));
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
